// File: rtl/inst_sram_resp.sv
// inst_sram_resp: single-port instruction SRAM with a fixed-latency read
// response and an independent word-write load port.
//
// Ports
//   clk        rising-edge clock for every state element
//   rst_n      asynchronous active-low reset (memory contents are not reset)
//   mem_ren    read request from the fetch unit
//   mem_addr   byte address of the read request
//   req_ready  high while a request can be accepted (FSM idle)
//   rdata      read data, valid while rvalid is high
//   rvalid     response valid; held until rready
//   rerr       request was misaligned or outside the memory window
//   rready     consumer takes the response
//   we         load-port word write enable
//   waddr      load-port byte address
//   wdata      load-port write data
module inst_sram_resp #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          AW      = 10,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic [31:0] mem_addr,
  output logic        req_ready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        rerr,
  input  logic        rready,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata
);

  localparam int unsigned DEPTH    = 32'd1 << AW;
  // Wait-state count loaded on accept; unused when LATENCY is 1.
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Aligned and inside the window; addresses below BASE wrap to a huge offset.
  function automatic logic addr_ok(input logic [1:0] lo, input logic [31:0] off);
    return (lo == 2'b00) && ((off >> 2) < DEPTH);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] rd_addr_s;
  logic [31:0] rd_off_s;
  logic        rd_ok_s;
  logic [31:0] rd_word_s;
  logic [31:0] wr_off_s;
  logic        wr_ok_s;

  // With LATENCY 1 the response is built on the accept edge, straight from mem_addr.
  assign rd_addr_s = (state_q == IDLE) ? mem_addr : addr_q;
  assign rd_off_s  = rd_addr_s - BASE;
  assign rd_ok_s   = addr_ok(rd_addr_s[1:0], rd_off_s);
  // Reads the pre-edge array contents, so a same-edge write is not seen.
  assign rd_word_s = rd_ok_s ? mem_q[rd_off_s[AW+1:2]] : 32'd0;

  assign wr_off_s  = waddr - BASE;
  assign wr_ok_s   = addr_ok(waddr[1:0], wr_off_s);

  assign req_ready = (state_q == IDLE);
  assign rvalid    = (state_q == RESP);
  assign rdata     = rdata_q;
  assign rerr      = rerr_q;

  // Next-state logic for the request/response FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE: begin
        if (mem_ren) begin
          addr_d = mem_addr;
          if (LATENCY == 1) begin
            state_d = RESP;
            rdata_d = rd_word_s;
            rerr_d  = ~rd_ok_s;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = rd_word_s;
          rerr_d  = ~rd_ok_s;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Returning to IDLE here; the next request is taken one edge later.
        if (rready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state and response registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      rdata_q <= 32'd0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Load-port write; independent of the FSM and of reset, bad addresses dropped.
  always_ff @(posedge clk) begin
    if (we && wr_ok_s) begin
      mem_q[wr_off_s[AW+1:2]] <= wdata;
    end
  end

endmodule

// File: tb/tb_inst_sram_resp.sv
module tb_inst_sram_resp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          NDUT  = 3;

  logic        clk;
  logic        rst_n;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic        rready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  logic        req_ready_a [NDUT];
  logic [31:0] rdata_a     [NDUT];
  logic        rvalid_a    [NDUT];
  logic        rerr_a      [NDUT];

  // Instance k runs with LATENCY = k+1; all share the same stimulus.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inst_sram_resp #(
      .BASE   (BASE),
      .AW     (10),
      .LATENCY(g + 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_ren  (mem_ren),
      .mem_addr (mem_addr),
      .req_ready(req_ready_a[g]),
      .rdata    (rdata_a[g]),
      .rvalid   (rvalid_a[g]),
      .rerr     (rerr_a[g]),
      .rready   (rready),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: memory image plus, per instance, the outstanding request
  // described by its accept edge number and the response it must produce.
  logic [31:0] mem_m [DEPTH];
  bit          m_busy [NDUT];
  int          m_acc  [NDUT];
  logic [31:0] m_addr [NDUT];
  bit          m_rv   [NDUT];
  logic [31:0] m_data [NDUT];
  bit          m_err  [NDUT];

  function automatic bit addr_good(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 == 0) && (off < 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (addr_good(a)) return mem_m[int'(off / 4)];
    else return 32'd0;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return BASE + 32'($urandom_range(0, 15)) * 32'd4;
      4:          return BASE + 32'd4092;
      5:          return BASE + 32'd4096;
      6:          return BASE - 32'd4;
      default:    return BASE + 32'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_busy[k] = 1'b0;
      m_rv[k]   = 1'b0;
      m_data[k] = 32'd0;
      m_err[k]  = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s L=%0d observed=%h expected=%h", tag, k + 1, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      chk("req_ready", k, 32'(req_ready_a[k]), 32'(!m_busy[k]));
      chk("rvalid", k, 32'(rvalid_a[k]), 32'(m_rv[k]));
      if (m_rv[k] || !rst_n) begin
        chk("rdata", k, rdata_a[k], m_data[k]);
        chk("rerr", k, 32'(rerr_a[k]), 32'(m_err[k]));
      end
    end
  endtask

  // One rising edge: predict its effect from the current inputs, apply it,
  // then check all instances at the following falling edge.
  task automatic tick();
    bit was_busy;
    edge_n++;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        was_busy = m_busy[k];
        if (was_busy && m_rv[k] && rready) begin
          m_busy[k] = 1'b0;
          m_rv[k]   = 1'b0;
        end
        if (!was_busy && mem_ren) begin
          m_busy[k] = 1'b1;
          m_acc[k]  = edge_n;
          m_addr[k] = mem_addr;
        end
        // Response appears on edge number LATENCY counting the accept edge as 1.
        if (m_busy[k] && !m_rv[k] && edge_n == m_acc[k] + k) begin
          m_rv[k]   = 1'b1;
          m_data[k] = mem_read(m_addr[k]);
          m_err[k]  = !addr_good(m_addr[k]);
        end
      end
    end
    if (we && addr_good(waddr)) mem_m[int'((waddr - BASE) / 4)] = wdata;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic read_req(input logic [31:0] a);
    mem_ren  = 1'b1;
    mem_addr = a;
    tick();
    mem_ren = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_ren  = 1'b0;
    mem_addr = 32'd0;
    rready   = 1'b1;
    we       = 1'b0;
    waddr    = 32'd0;
    wdata    = 32'd0;
    model_reset();

    // Reset state, with a request pending that must not be accepted.
    mem_ren = 1'b1;
    mem_addr = BASE;
    tick();
    tick();
    mem_ren = 1'b0;
    rst_n   = 1'b1;

    // Fill the whole array so every read has a known value.
    we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      waddr = BASE + 32'(i) * 32'd4;
      wdata = $urandom;
      tick();
    end
    we = 1'b0;

    // Basic read with known data.
    we = 1'b1; waddr = BASE; wdata = 32'h0000_0413;
    tick();
    we = 1'b0;
    mem_ren = 1'b1; mem_addr = BASE; rready = 1'b1;
    tick();
    mem_ren = 1'b0;
    tick();
    chk("basic_rdata", 1, rdata_a[1], 32'h0000_0413);
    chk("basic_rvalid", 1, 32'(rvalid_a[1]), 32'd1);
    tick();
    chk("basic_ready_back", 1, 32'(req_ready_a[1]), 32'd1);
    repeat (3) tick();

    // Address checks: misaligned, below BASE, one past the end, last word.
    read_req(BASE + 32'd2);
    read_req(BASE - 32'd4);
    read_req(BASE + 32'd4096);
    read_req(BASE + 32'd4092);

    // Back-pressure: response held while mem_ren/mem_addr toggle.
    rready = 1'b0;
    mem_ren = 1'b1; mem_addr = BASE + 32'd12;
    tick();
    for (int i = 0; i < 8; i++) begin
      mem_ren  = (i % 2 == 0);
      mem_addr = pick_addr();
      tick();
    end
    mem_ren = 1'b0;
    rready  = 1'b1;
    repeat (4) tick();

    // Read-before-write: write on edge 2 is visible to LATENCY 3, on edge 3 not.
    we = 1'b1; waddr = BASE + 32'd16; wdata = 32'h1111_1111;
    tick();
    we = 1'b0;
    mem_ren = 1'b1; mem_addr = BASE + 32'd16;
    tick();
    mem_ren = 1'b0;
    we = 1'b1; wdata = 32'h2222_2222;
    tick();
    we = 1'b0;
    tick();
    chk("rbw_edge2", 2, rdata_a[2], 32'h2222_2222);
    repeat (3) tick();
    we = 1'b1; wdata = 32'h1111_1111;
    tick();
    we = 1'b0;
    mem_ren = 1'b1;
    tick();
    mem_ren = 1'b0;
    tick();
    we = 1'b1; wdata = 32'h2222_2222;
    tick();
    we = 1'b0;
    chk("rbw_edge3", 2, rdata_a[2], 32'h1111_1111);
    repeat (3) tick();

    // Asynchronous reset one cycle after accept aborts the response.
    mem_ren = 1'b1; mem_addr = BASE + 32'd8;
    tick();
    mem_ren = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    mem_ren = 1'b1;
    tick();
    tick();
    mem_ren = 1'b0;
    rst_n   = 1'b1;
    read_req(BASE + 32'd8);

    // Streaming with mem_ren and rready held high, then reset preserves memory.
    mem_ren = 1'b1; rready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_addr = BASE + 32'($urandom_range(0, 15)) * 32'd4;
      tick();
    end
    mem_ren = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    read_req(BASE);
    read_req(BASE + 32'd16);

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      mem_ren  = $urandom_range(0, 1) == 1;
      mem_addr = pick_addr();
      rready   = $urandom_range(0, 3) != 0;
      we       = rst_n && ($urandom_range(0, 3) == 0);
      waddr    = pick_addr();
      wdata    = $urandom;
      tick();
    end
    rst_n = 1'b1;
    we    = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000: byte address of word 0.
REQ-002 SHALL have parameter AW, default 10: word-index width, so DEPTH = 2^AW words.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request accept to rvalid; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mem_ren, input, 1 bit: read request from the fetch unit.
REQ-007 SHALL have port mem_addr, input, 32 bits: byte address of the read request.
REQ-008 SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-009 SHALL have port rdata, output, 32 bits: read data.
REQ-010 SHALL have port rvalid, output, 1 bit: rdata and rerr are valid.
REQ-011 SHALL have port rerr, output, 1 bit: the request was misaligned or out of range.
REQ-012 SHALL have port rready, input, 1 bit: the consumer takes the response.
REQ-013 SHALL have port we, input, 1 bit: load-port word write enable.
REQ-014 SHALL have ports waddr (input, 32 bits) and wdata (input, 32 bits): load-port byte address and write data.

Function
REQ-015 SHALL implement states IDLE, WAIT and RESP; req_ready = (state==IDLE), and rvalid = (state==RESP).
REQ-016 SHALL accept a request at a rising edge where state==IDLE and mem_ren==1, latching mem_addr into an internal address register.
REQ-017 On accept, SHALL go to RESP if LATENCY==1, otherwise to WAIT with cnt = LATENCY-2.
REQ-018 In WAIT, SHALL go to RESP when cnt==0, otherwise decrement cnt.
REQ-019 rvalid SHALL rise exactly LATENCY rising edges after the accept edge, counting the accept edge as edge 1.
REQ-020 On entering RESP, SHALL register rdata and rerr from the latched address; both SHALL hold stable while in RESP.
REQ-021 In RESP with rready==1, SHALL return to IDLE; rvalid SHALL deassert after that edge.
REQ-022 A new request SHALL NOT be accepted on the same edge that completes a response.
REQ-023 In RESP with rready==0, SHALL remain in RESP indefinitely.
REQ-024 mem_ren in WAIT or RESP SHALL be ignored and SHALL NOT be queued.
REQ-025 Address check: misaligned = (addr[1:0] != 0); offset = addr - BASE (32-bit modulo); in range = (offset >> 2) < DEPTH.
REQ-026 An address below BASE wraps to a large offset and SHALL be treated as out of range.
REQ-027 A misaligned or out-of-range read SHALL give rerr=1 and rdata=0; otherwise rerr=0 and rdata = mem[offset[AW+1:2]].
REQ-028 Writes: at any rising edge with we==1 and a valid aligned in-range waddr, SHALL write mem[index] = wdata, independent of FSM state.
REQ-029 A write with a misaligned or out-of-range waddr SHALL be silently dropped.
REQ-030 Read sampling is read-before-write: a write to the same word on the WAIT->RESP (or IDLE->RESP) edge SHALL NOT be visible in rdata; a write on any earlier edge SHALL be visible.
REQ-031 Memory contents SHALL have no reset value and SHALL be unaffected by rst_n.

Reset
REQ-032 While rst_n==0: state=IDLE, cnt=0, rdata=0, rerr=0, rvalid=0, latched address=0, and req_ready=1, effective immediately (asynchronous).
REQ-033 Reset asserted in WAIT or RESP SHALL abort the pending response with no rvalid pulse; the first request after release SHALL follow the REQ-016..REQ-021 timing.
REQ-034 No request SHALL be accepted on a rising edge where rst_n==0.

Verification
REQ-035 LATENCY=2: write 0x00000413 to 0x80000000, then request that address with rready=1 -> rvalid high exactly 2 edges after accept, rdata=0x00000413, rerr=0, req_ready back high on the following cycle.
REQ-036 Request 0x80000002 -> rerr=1, rdata=0; request 0x7FFFFFFC -> rerr=1 (wrap); request BASE+4*DEPTH -> rerr=1; request BASE+4*(DEPTH-1) -> rerr=0.
REQ-037 Hold rready=0 for 5 cycles in RESP while toggling mem_ren and mem_addr -> rvalid, rdata and rerr stable, no new accept; release rready -> exactly one response completes.
REQ-038 LATENCY=3, word 0x80000010 = 0x11111111: write 0x22222222 there on edge 2 after accept -> response 0x22222222; repeat with the write on edge 3 -> response 0x11111111.
REQ-039 Pull rst_n low one cycle after accept -> rvalid stays 0 and req_ready=1 immediately; a post-reset request returns the correct data with normal latency.
REQ-040 LATENCY=1 with mem_ren held high and rready held high -> responses on alternating cycles (accept, RESP, accept, ...), and memory contents are preserved across a reset.
